// File: rtl/seq_1011_pkg.sv
// Shared definitions for the serial "1011" link: transmitter states, detector
// tracker states and the pattern itself.
package seq_1011_pkg;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_SHIFT = 2'd1,
      TX_GAP   = 2'd2
   } tx_state_t;

   typedef enum logic [2:0] {
      T_IDLE = 3'd0,
      T_1    = 3'd1,
      T_10   = 3'd2,
      T_101  = 3'd3,
      T_1011 = 3'd4
   } trk_state_t;

   localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq_1011_model.sv
// Cycle-exact model of the downstream 1011 detector. After a match the
// following bit is consumed without being examined.
module seq_1011_model
   import seq_1011_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic bit_in,
   output logic match
);

   trk_state_t r_state;
   trk_state_t w_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= T_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // T_1 holds on a repeated 1 so that "11..." prefixes still line up
   always_comb begin
      w_next = T_IDLE;
      case (r_state)
         T_IDLE: w_next = (bit_in == PATTERN[3]) ? T_1    : T_IDLE;
         T_1:    w_next = (bit_in == PATTERN[2]) ? T_10   : T_1;
         T_10:   w_next = (bit_in == PATTERN[1]) ? T_101  : T_IDLE;
         T_101:  w_next = (bit_in == PATTERN[0]) ? T_1011 : T_IDLE;
         T_1011: w_next = T_IDLE;
         default: w_next = T_IDLE;
      endcase
   end

   assign match = (r_state == T_1011);

endmodule

// File: rtl/seq_1011_gen.sv
// Serial pattern transmitter: accepts parallel words over valid/ready and
// shifts them out MSB-first, with optional idle gaps and a golden detector.
module seq_1011_gen
   import seq_1011_pkg::*;
#(
   parameter int W   = 8,
   parameter int GAP = 0,
   parameter int CW  = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          ser_out,
   output logic          ser_valid,
   output logic          busy,
   output logic          exp_match,
   output logic [CW-1:0] match_cnt
);

   localparam int          BW       = (W > 1) ? $clog2(W) : 1;
   localparam logic [7:0]  GAP_INIT = 8'(GAP);

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + CW'(1);
   endfunction

   tx_state_t     r_state;
   tx_state_t     w_next_state;
   logic [W-1:0]  r_shreg;
   logic [BW-1:0] r_bits_left;
   logic [7:0]    r_gap_cnt;
   logic          r_ser;
   logic          r_ser_valid;
   logic [CW-1:0] r_match_cnt;

   logic w_last_bit;
   logic w_gap_last;
   logic w_accept;
   logic w_match;

   assign w_last_bit = (r_state == TX_SHIFT) && (r_bits_left == '0);
   assign w_gap_last = (r_state == TX_GAP) && (r_gap_cnt == 8'd1);

   // Ready depends only on state and counters so upstream can wait on it freely
   always_comb begin
      in_ready = 1'b0;
      case (r_state)
         TX_IDLE:  in_ready = 1'b1;
         TX_SHIFT: in_ready = w_last_bit && (GAP == 0);
         TX_GAP:   in_ready = w_gap_last;
         default:  in_ready = 1'b0;
      endcase
   end

   assign w_accept = in_valid && in_ready;

   always_comb begin
      w_next_state = r_state;
      if (w_accept) begin
         w_next_state = TX_SHIFT;
      end else begin
         case (r_state)
            TX_SHIFT: if (w_last_bit) w_next_state = (GAP > 0) ? TX_GAP : TX_IDLE;
            TX_GAP:   if (w_gap_last) w_next_state = TX_IDLE;
            default:  w_next_state = r_state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= TX_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shreg     <= '0;
         r_bits_left <= '0;
         r_gap_cnt   <= '0;
         r_ser       <= 1'b0;
         r_ser_valid <= 1'b0;
      end else if (w_accept) begin
         r_ser       <= in_data[W-1];
         r_ser_valid <= 1'b1;
         r_shreg     <= in_data << 1;
         r_bits_left <= BW'(W - 1);
      end else begin
         case (r_state)
            TX_SHIFT: begin
               if (r_bits_left != '0) begin
                  r_ser       <= r_shreg[W-1];
                  r_shreg     <= r_shreg << 1;
                  r_bits_left <= r_bits_left - BW'(1);
               end else begin
                  r_ser       <= 1'b0;
                  r_ser_valid <= 1'b0;
                  r_gap_cnt   <= GAP_INIT;
               end
            end
            TX_GAP: begin
               r_gap_cnt <= r_gap_cnt - 8'd1;
            end
            default: begin
               r_ser       <= 1'b0;
               r_ser_valid <= 1'b0;
            end
         endcase
      end
   end

   // Tracker sees the line exactly as the receiver does, idle zeros included
   seq_1011_model u_model (
      .clk    (clk),
      .rst    (rst),
      .bit_in (r_ser),
      .match  (w_match)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_match_cnt <= '0;
      end else if (w_match) begin
         r_match_cnt <= sat_inc(r_match_cnt);
      end
   end

   assign ser_out   = r_ser;
   assign ser_valid = r_ser_valid;
   assign busy      = (r_state != TX_IDLE);
   assign exp_match = w_match;
   assign match_cnt = r_match_cnt;

endmodule
